// File: rtl/imem_boot_loader_pkg.sv
// Shared constants for the instruction-memory boot loader.
// FSM encoding, default memory size and the 4-byte word size.
package imem_boot_loader_pkg;

    localparam int MEM_BYTES_DEF = 1024;
    localparam int WORD_BYTES    = 4;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RECV  = 2'd1;
    localparam logic [1:0] ST_WRITE = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream valid/ready link between a byte source and the loader.
// master = byte source, slave = loader.
interface imem_boot_loader_if;

    logic       Byte_Valid;
    logic [7:0] Byte_Data;
    logic       Byte_Ready;

    modport master (
        output Byte_Valid,
        output Byte_Data,
        input  Byte_Ready
    );

    modport slave (
        input  Byte_Valid,
        input  Byte_Data,
        output Byte_Ready
    );

endinterface

// File: rtl/imem_boot_loader_packer.sv
// byte_word_packer: shifts bytes into a big-endian 32-bit word.
// last flags the 4th byte slot; full holds until the word is taken.
module byte_word_packer
    import imem_boot_loader_pkg::*;
(
    input  logic        CLK,
    input  logic        Reset,
    input  logic        clr,
    input  logic        push,
    input  logic        take,
    input  logic [7:0]  din,
    output logic [31:0] word,
    output logic        last,
    output logic        full
);

    logic [1:0] cnt;

    assign last = (cnt == 2'(WORD_BYTES - 1));

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            cnt  <= '0;
            word <= '0;
            full <= 1'b0;
        end else if (clr) begin
            cnt  <= '0;
            word <= '0;
            full <= 1'b0;
        end else begin
            if (push) begin
                word <= {word[23:0], din};
                cnt  <= cnt + 2'd1;
            end
            if (push && last)
                full <= 1'b1;
            else if (take)
                full <= 1'b0;
        end
    end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: streams bytes into instruction memory, stalling the core.
// Optional trailing checksum word when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_boot_loader
    import imem_boot_loader_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DEF,
    parameter int AW        = 10
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                Start,
    input  logic [AW-2:0]       Load_Len,
    imem_boot_loader_if.slave   bs,
    input  logic [31:0]         Fetch_A,
    output logic [31:0]         Mem_A,
    output logic                Mem_WE,
    output logic [31:0]         Mem_WD,
    output logic                Core_Stall,
    output logic                Busy,
    output logic                Done,
    output logic                Error
);

    localparam int MAX_WORDS = MEM_BYTES / WORD_BYTES;

    logic [1:0]    state;
    logic [AW-2:0] len;
    logic [AW-2:0] wcnt;
    logic [AW-1:0] addr;
    logic          err_q;
    logic          len_ok;
    logic          start_ok;
    logic          last_word;
    logic          push;
    logic          last;
    logic          full;
    logic [31:0]   word;

    assign len_ok    = (Load_Len != '0) &&
                       (32'(Load_Len) <= 32'(MAX_WORDS));
    assign start_ok  = (state == ST_IDLE) && Start && len_ok;
    assign last_word = (wcnt == len - 1'b1);

    assign bs.Byte_Ready = (state == ST_RECV);
    assign push          = bs.Byte_Valid && bs.Byte_Ready;

    byte_word_packer u_pack (
        .CLK   (CLK),
        .Reset (Reset),
        .clr   (start_ok),
        .push  (push),
        .take  (state == ST_WRITE),
        .din   (bs.Byte_Data),
        .word  (word),
        .last  (last),
        .full  (full)
    );

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] sum;
    logic        ck_phase;

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            sum      <= '0;
            ck_phase <= 1'b0;
        end else if (start_ok) begin
            sum      <= '0;
            ck_phase <= 1'b0;
        end else if (state == ST_WRITE) begin
            sum <= sum + word;
            if (last_word)
                ck_phase <= 1'b1;
        end
    end

    // The checksum word sits in the packer once FIN is reached.
    assign Done  = (state == ST_FIN) && (sum == word);
    assign Error = err_q || ((state == ST_FIN) && (sum != word));
`else
    assign Done  = (state == ST_FIN);
    assign Error = err_q;
`endif

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state <= ST_IDLE;
            len   <= '0;
            wcnt  <= '0;
            addr  <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= (state == ST_IDLE) && Start && !len_ok;
            unique case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        len   <= Load_Len;
                        wcnt  <= '0;
                        addr  <= '0;
                        state <= ST_RECV;
                    end
                end
                ST_RECV: begin
                    if (push && last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state <= ck_phase ? ST_FIN : ST_WRITE;
`else
                        state <= ST_WRITE;
`endif
                    end
                end
                ST_WRITE: begin
                    addr <= addr + AW'(WORD_BYTES);
                    wcnt <= wcnt + 1'b1;
                    if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state <= ST_RECV;
`else
                        state <= ST_FIN;
`endif
                    end else begin
                        state <= ST_RECV;
                    end
                end
                ST_FIN: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign Busy       = (state != ST_IDLE);
    assign Core_Stall = Busy;
    assign Mem_WE     = (state == ST_WRITE) && full;
    assign Mem_WD     = word;
    assign Mem_A      = (state == ST_IDLE) ? Fetch_A : 32'(addr);

endmodule

// File: tb/tb_imem_boot_loader.sv
// Randomized self-checking bench for imem_boot_loader.
// Reference: expected writes derived from the byte stream directly.
module tb_imem_boot_loader;

    logic        CLK = 1'b0;
    logic        Reset = 1'b0;
    logic        Start = 1'b0;
    logic [8:0]  Load_Len = '0;
    logic [31:0] Fetch_A = '0;
    logic [31:0] Mem_A;
    logic        Mem_WE;
    logic [31:0] Mem_WD;
    logic        Core_Stall;
    logic        Busy;
    logic        Done;
    logic        Error;

    imem_boot_loader_if bif ();

    imem_boot_loader dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .Start      (Start),
        .Load_Len   (Load_Len),
        .bs         (bif.slave),
        .Fetch_A    (Fetch_A),
        .Mem_A      (Mem_A),
        .Mem_WE     (Mem_WE),
        .Mem_WD     (Mem_WD),
        .Core_Stall (Core_Stall),
        .Busy       (Busy),
        .Done       (Done),
        .Error      (Error)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int n_done = 0;
    int n_err = 0;
    int n_busy = 0;
    int done_cyc = 0;
    int last_hs = 0;
    int stall_lo = 0;
    bit in_load = 0;

    logic [31:0] obs_a[$];
    logic [31:0] obs_d[$];
    logic [31:0] wd[$];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (Mem_WE) begin
            obs_a.push_back(Mem_A);
            obs_d.push_back(Mem_WD);
        end
        if (Done) begin
            n_done++;
            done_cyc = cyc;
        end
        if (Error) n_err++;
        if (Busy) n_busy++;
        if (in_load && !Core_Stall) stall_lo++;
    end

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_rdy"}, 32'(bif.Byte_Ready), 32'd0);
        check({tag, "_we"}, 32'(Mem_WE), 32'd0);
        check({tag, "_wd"}, Mem_WD, 32'd0);
        check({tag, "_stall"}, 32'(Core_Stall), 32'd0);
        check({tag, "_busy"}, 32'(Busy), 32'd0);
        check({tag, "_done"}, 32'(Done), 32'd0);
        check({tag, "_err"}, 32'(Error), 32'd0);
    endtask

    task automatic check_fetch();
        for (int i = 0; i < 2; i++) begin
            Fetch_A = $urandom;
            #1;
            check("fetch_mux", Mem_A, Fetch_A);
        end
    endtask

    // gap: 0 none, 1 low cycle before every byte, 2 random
    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        bit ok;
        if (gap == 1 || (gap == 2 && $urandom_range(0, 1) == 1)) begin
            bif.Byte_Valid = 1'b0;
            @(posedge CLK);
            #1;
        end
        bif.Byte_Data  = b;
        bif.Byte_Valid = 1'b1;
        ok = 0;
        for (t = 0; t < 50 && !ok; t++) begin
            @(negedge CLK);
            if (bif.Byte_Ready) begin
                ok = 1;
                last_hs = cyc;
            end
            @(posedge CLK);
            #1;
        end
        bif.Byte_Valid = 1'b0;
        if (!ok) check("byte_tmo", 32'(ok), 32'd1);
    endtask

    task automatic run_load(input int gap,
                            input bit mid_start,
                            input bit ck_bad);
        int len, d0, e0, t;
        bit fin, exp_ok;
        logic [31:0] sum;
        len = wd.size();
        obs_a.delete();
        obs_d.delete();
        d0 = n_done;
        e0 = n_err;
        sum = '0;
        exp_ok = 1;
        Load_Len = 9'(len);
        Start = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        Load_Len = '0;
        in_load = 1;
        stall_lo = 0;
        for (int w = 0; w < len; w++) begin
            for (int k = 0; k < 4; k++) begin
                send_byte(wd[w][31-8*k -: 8], gap);
                if (mid_start && w == 0 && k == 1) begin
                    Load_Len = 9'(len + 2);
                    Start = 1'b1;
                    @(posedge CLK);
                    #1;
                    Start = 1'b0;
                end
            end
            sum = sum + wd[w];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (ck_bad) begin
            sum = sum + 32'd1;
            exp_ok = 0;
        end
        for (int k = 0; k < 4; k++)
            send_byte(sum[31-8*k -: 8], gap);
`else
        if (ck_bad) exp_ok = 1;
`endif
        fin = 0;
        for (t = 0; t < 20 && !fin; t++) begin
            @(negedge CLK);
            #1;
            fin = (n_done != d0) || (n_err != e0);
        end
        in_load = 0;
        repeat (2) @(posedge CLK);
        #1;
        check("fin_tmo", 32'(fin), 32'd1);
        check("n_wr", 32'(obs_a.size()), 32'(len));
        for (int i = 0; i < len && i < obs_a.size(); i++) begin
            check("wr_a", obs_a[i], 32'(4 * i));
            check("wr_d", obs_d[i], wd[i]);
        end
        check("done", 32'(n_done - d0), 32'(exp_ok));
        check("err", 32'(n_err - e0), 32'(!exp_ok));
        check("stall", 32'(stall_lo), 32'd0);
`ifndef IMEM_LOADER_CHECKSUM_EN
        check("done_lat", 32'(done_cyc - last_hs), 32'd2);
`endif
    endtask

    task automatic bad_start(input logic [8:0] l);
        int e0, b0, w0;
        e0 = n_err;
        b0 = n_busy;
        w0 = obs_a.size();
        Load_Len = l;
        Start = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        check("bad_err", 32'(n_err - e0), 32'd1);
        check("bad_busy", 32'(n_busy - b0), 32'd0);
        check("bad_we", 32'(obs_a.size()), 32'(w0));
    endtask

    initial begin
        bif.Byte_Valid = 1'b0;
        bif.Byte_Data  = '0;
        repeat (2) @(negedge CLK);
        check_quiet("rst");
        @(posedge CLK);
        #1;
        Reset = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check_fetch();

        wd = '{32'h00500113};
        run_load(0, 0, 0);

        wd = '{32'h00C00193, 32'hFF718393};
        run_load(1, 0, 0);

        bad_start(9'd0);
        bad_start(9'd257);

        wd = '{$urandom, $urandom, $urandom};
        run_load(2, 1, 0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        wd = '{32'h00500113};
        run_load(0, 0, 1);
`endif

        Load_Len = 9'd1;
        Start = 1'b1;
        @(posedge CLK);
        #1;
        Start = 1'b0;
        obs_a.delete();
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        Reset = 1'b0;
        #1;
        check_quiet("midrst");
        repeat (2) @(negedge CLK);
        check_quiet("midrst2");
        @(posedge CLK);
        #1;
        Reset = 1'b1;
        check("midrst_wr", 32'(obs_a.size()), 32'd0);
        check_fetch();
        wd = '{$urandom};
        run_load(0, 0, 0);

        for (int r = 0; r < 6; r++) begin
            wd.delete();
            for (int i = 0; i < $urandom_range(1, 12); i++)
                wd.push_back($urandom);
            run_load(2, 0, 0);
            check_fetch();
        end

        wd.delete();
        for (int i = 0; i < 256; i++)
            wd.push_back($urandom);
        run_load(0, 0, 0);
        check_fetch();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/imem_boot_loader.md
IMEM_BOOT_LOADER -- requirements
Module: imem_boot_loader

Interface
REQ-001 SHALL have parameter MEM_BYTES, default 1024, meaning instruction memory size in bytes, byte-addressed.
REQ-002 SHALL have parameter AW, default 10, meaning the byte address width, equal to log2(MEM_BYTES).
REQ-003 SHALL have port CLK, in, 1, system clock; all state changes on the rising edge.
REQ-004 SHALL have port Reset, in, 1, asynchronous active-low reset.
REQ-005 SHALL have port Start, in, 1, a 1-cycle request to begin a load.
REQ-006 SHALL have port Load_Len, in, AW-1, the number of 32-bit words to load, sampled when Start is accepted.
REQ-007 SHALL have port Byte_Valid, in, 1, which marks the source byte as valid.
REQ-008 SHALL have port Byte_Data, in, 8, the source byte.
REQ-009 SHALL have port Byte_Ready, out, 1; the loader accepts a byte when Byte_Valid and Byte_Ready are both high.
REQ-010 SHALL have port Fetch_A, in, 32, the core fetch address.
REQ-011 SHALL have port Mem_A, out, 32, the address driven to instruction memory.
REQ-012 SHALL have port Mem_WE, out, 1, the memory word write enable.
REQ-013 SHALL have port Mem_WD, out, 32, the write word, with the first received byte at bits [31:24] (big-endian, byte at A is the MSB).
REQ-014 SHALL have port Core_Stall, out, 1, which holds the core PC and fetch while a load runs.
REQ-015 SHALL have ports Busy, Done and Error, out, 1 each; Busy is a level, Done and Error are 1-cycle pulses.

Function
REQ-016 SHALL implement the FSM states IDLE, RECV, WRITE and FIN.
REQ-017 IDLE: on Start with 1 <= Load_Len <= MEM_BYTES/4, SHALL latch Load_Len, clear the word address and byte counter, and go to RECV.
REQ-018 IDLE: on Start with Load_Len = 0 or Load_Len > MEM_BYTES/4, SHALL pulse Error for 1 cycle and stay in IDLE.
REQ-019 RECV: SHALL drive Byte_Ready = 1 and shift each accepted byte into the word, with the earlier byte more significant; the byte counter counts 0..3.
REQ-020 RECV: when the 4th byte is accepted, SHALL go to WRITE on the next edge; Byte_Ready SHALL be 0 in WRITE.
REQ-021 WRITE: SHALL assert Mem_WE for exactly 1 cycle with Mem_A = word address and Mem_WD = the assembled word, then add 4 to the word address.
REQ-022 WRITE: after the last word, SHALL go to FIN; otherwise it returns to RECV.
REQ-023 FIN: SHALL pulse Done for 1 cycle and go to IDLE.
REQ-024 Busy and Core_Stall SHALL be 1 in RECV, WRITE and FIN, and 0 in IDLE.
REQ-025 Mem_A SHALL equal Fetch_A when the FSM is in IDLE, and the loader address otherwise (a combinational mux).
REQ-026 Start while the FSM is not in IDLE SHALL be ignored.
REQ-027 Byte_Valid low while in RECV SHALL stall without timeout, with no change in state.
REQ-028 A load of MEM_BYTES/4 words SHALL end with the last write at address MEM_BYTES-4, with no address wrap.
REQ-029 Start and Done SHALL never overlap, because Done is issued only from FIN and Start is only accepted in IDLE.

Reset
REQ-030 While Reset = 0, the FSM SHALL be in IDLE, all counters SHALL be 0, and the partial word SHALL be 0.
REQ-031 While Reset = 0, Byte_Ready, Mem_WE, Mem_WD, Core_Stall, Busy, Done and Error SHALL be 0.
REQ-032 Reset asserted mid-load SHALL abort immediately, with no further writes and no Done; memory already written is left as is.

Configuration
REQ-033 With IMEM_LOADER_CHECKSUM_EN defined, SHALL keep a 32-bit wrap-around sum of all written words.
REQ-034 With IMEM_LOADER_CHECKSUM_EN defined, after the last word SHALL receive 4 more bytes as the expected sum, which are not written to memory.
REQ-035 With IMEM_LOADER_CHECKSUM_EN defined, on a sum match SHALL pulse Done; on a mismatch SHALL pulse Error instead of Done; both then go to IDLE.
REQ-036 Without IMEM_LOADER_CHECKSUM_EN, no sum logic SHALL exist, and FIN follows the last WRITE.

Structure
REQ-037 A shared package SHALL hold the FSM state encoding, the MEM_BYTES default and the word size of 4 bytes.
REQ-038 The byte-to-word assembler SHALL be a sub-module, byte_word_packer (shift register, byte counter and full flag).

Verification
REQ-039 Reset = 0 mid-RECV after 2 bytes -> every output is 0 and the FSM is in IDLE; a fresh load of 1 word then writes to address 0.
REQ-040 Load_Len = 1, bytes 00 50 01 13 -> one Mem_WE with Mem_A = 0 and Mem_WD = 32'h00500113, then Done 2 cycles later.
REQ-041 Load_Len = 2, bytes 00 C0 01 93 FF 71 83 93 with Byte_Valid toggled every other cycle -> writes 32'h00C00193 at address 0 and 32'hFF718393 at address 4, with Core_Stall high throughout.
REQ-042 Start with Load_Len = 0, and again with Load_Len = 257 -> one Error pulse each, no Mem_WE, Busy stays 0.
REQ-043 Start pulsed during RECV -> ignored, and the load completes with the original Load_Len.
REQ-044 With IMEM_LOADER_CHECKSUM_EN: 1 word 32'h00500113 followed by checksum bytes 00 50 01 13 -> Done; checksum bytes 00 50 01 14 -> Error and no Done.
